// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack deck datapath: card word layout,
// rank constants, deck geometry and the dealer state encoding.
package blackjack_pkg;

   localparam int DECK_SIZE      = 52;

   // Card word layout: {valid, suit[1:0], rank[3:0]}
   localparam int CARD_VALID_BIT = 6;
   localparam int RANK_MSB       = 3;
   localparam int RANK_LSB       = 0;

   localparam logic [3:0] RANK_ACE  = 4'd1;
   localparam logic [3:0] RANK_TEN  = 4'd10;
   localparam logic [3:0] RANK_KING = 4'd13;

   typedef enum logic [1:0] {
      ST_WAIT_LOAD,
      ST_IDLE,
      ST_READ,
      ST_CAPTURE
   } dealer_state_e;

endpackage

// File: rtl/card_value_decode.sv
// Combinational blackjack value decode of one card word.
// Malformed words (loader flag clear, rank 0 or rank above king) report
// value 0 and are flagged bad; face cards count 10, aces count 1.
module card_value_decode
   import blackjack_pkg::*;
(
   input  logic       card_flag,
   input  logic [3:0] rank,
   output logic [3:0] value,
   output logic       is_ace,
   output logic       bad
);

   // Rank to value mapping with malformed-word detection
   always_comb begin
      value  = 4'd0;
      is_ace = 1'b0;
      bad    = 1'b0;
      if (!card_flag || (rank == 4'd0) || (rank > RANK_KING)) begin
         bad = 1'b1;
      end else if (rank == RANK_ACE) begin
         value  = 4'd1;
         is_ace = 1'b1;
      end else if (rank <= RANK_TEN) begin
         value = rank;
      end else begin
         value = RANK_TEN;
      end
   end

endmodule

// File: rtl/card_dealer.sv
// Deck RAM read-side dealer: fetches one card per accepted request,
// decodes its blackjack value and pulses card_valid, while tracking the
// deck pointer, remaining cards, cut-card threshold and exhaustion.
module card_dealer
   import blackjack_pkg::*;
#(
   parameter int DECK_SIZE = blackjack_pkg::DECK_SIZE,
   parameter int ADDR_W    = 6,
   parameter int CARD_W    = 7,
   parameter int CUT_MARK  = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_done,
   input  logic              restart,
   input  logic              deal_req,
   output logic              deal_ready,
   output logic [ADDR_W-1:0] deck_addr,
   output logic              deck_ren,
   input  logic [CARD_W-1:0] deck_data_out,
   output logic              card_valid,
   output logic [CARD_W-1:0] card,
   output logic [3:0]        card_value,
   output logic              card_is_ace,
   output logic              card_bad,
   output logic [ADDR_W-1:0] cards_left,
   output logic              deck_empty,
   output logic              reshuffle_due
);

   dealer_state_e     state_q, state_d;
   logic              load_done_q;
   logic              load_rise;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] dealt;
   logic [CARD_W-1:0] raw_p0;
   logic              vld_p0;
   logic [3:0]        dec_value;
   logic              dec_ace;
   logic              dec_bad;

   // load_done_q starts at 0, so a level held through reset reads as a new edge
   assign load_rise  = load_done && !load_done_q;
   assign deck_addr  = ptr;
   assign deck_empty = (state_q != ST_WAIT_LOAD) && (cards_left == '0);

   // Edge detector history for load_done; keeps tracking across restart
   always_ff @(posedge clk or posedge rst) begin
      if (rst) load_done_q <= 1'b0;
      else     load_done_q <= load_done;
   end

   // Dealer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_WAIT_LOAD;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs; restart overrides everything
   always_comb begin
      state_d    = state_q;
      deal_ready = 1'b0;
      deck_ren   = 1'b0;
      case (state_q)
         ST_WAIT_LOAD: begin
            if (load_rise) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            deal_ready = (cards_left != '0);
            if (deal_req && deal_ready) state_d = ST_READ;
         end
         ST_READ: begin
            deck_ren = 1'b1;
            state_d  = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_WAIT_LOAD;
      endcase
      if (restart) state_d = ST_WAIT_LOAD;
   end

   // Deck pointer and counters; they advance once per captured card
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         dealt      <= '0;
         cards_left <= '0;
      end else if (restart) begin
         ptr        <= '0;
         dealt      <= '0;
         cards_left <= '0;
      end else if ((state_q == ST_WAIT_LOAD) && load_rise) begin
         ptr        <= '0;
         dealt      <= '0;
         cards_left <= ADDR_W'(DECK_SIZE);
      end else if (state_q == ST_CAPTURE) begin
         ptr        <= ptr + ADDR_W'(1);
         dealt      <= dealt + ADDR_W'(1);
         cards_left <= cards_left - ADDR_W'(1);
      end
   end

   // Sticky cut-card flag, cleared only by restart or reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                reshuffle_due <= 1'b0;
      else if (restart)                       reshuffle_due <= 1'b0;
      else if (dealt >= ADDR_W'(CUT_MARK))    reshuffle_due <= 1'b1;
   end

   // ---- stage p0: RAM read data latched at the end of CAPTURE ----
   // Raw card word capture (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (state_q == ST_CAPTURE) raw_p0 <= deck_data_out;
   end

   card_value_decode u_decode (
      .card_flag (raw_p0[CARD_VALID_BIT]),
      .rank      (raw_p0[RANK_MSB:RANK_LSB]),
      .value     (dec_value),
      .is_ace    (dec_ace),
      .bad       (dec_bad)
   );

   // ---- stage p1: decoded card presented with a one-cycle valid pulse ----
   // Capture valid tracking and held card outputs; restart kills in-flight cards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0      <= 1'b0;
         card_valid  <= 1'b0;
         card_bad    <= 1'b0;
         card        <= '0;
         card_value  <= 4'd0;
         card_is_ace <= 1'b0;
      end else begin
         vld_p0     <= (state_q == ST_CAPTURE) && !restart;
         card_valid <= vld_p0 && !restart;
         card_bad   <= vld_p0 && !restart && dec_bad;
         if (vld_p0 && !restart) begin
            card        <= raw_p0;
            card_value  <= dec_value;
            card_is_ace <= dec_ace;
         end
      end
   end

endmodule
